key_fetch_client: RTL
=====================

Name: key_fetch_client

Overview:
- Requester side of the secure key store read path.
- Takes privileged fetch requests from a crypto engine and reads the secret key over a req/ack handshake.
- Presents the key for a bounded window, then zeroizes it.
- Enforces privilege, debug-mode blocking, read timeout and a sticky lockout after repeated faults.

Parameters:
- KEY_W, 32, key width in bits.
- TIMEOUT, 16, max cycles to wait for key_rd_ack (range 2..255).
- HOLD_MAX, 8, max cycles key stays valid without key_consume (range 1..255).
- MAX_ERR, 3, error count that triggers sticky lockout (range 1..15).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fetch_req  in  1  engine requests key; sampled only in IDLE.
- fetch_priv  in  1  requester privilege qualifier, sampled with fetch_req.
- debug_mode  in  1  debug/test access active; blocks fetches and forces zeroize.
- key_consume  in  1  engine has latched key; ends the delivery window.
- key_rd_req  out  1  read request to key store.
- key_rd_ack  in  1  key store response strobe; key_rd_data valid this cycle.
- key_rd_data  in  KEY_W  key from store.
- key_valid  out  1  key_out holds the live key.
- key_out  out  KEY_W  delivered key; all zeros whenever key_valid=0.
- fetch_done  out  1  one-cycle pulse on leaving a successful delivery.
- fetch_err  out  1  one-cycle pulse on a rejected or timed-out fetch.
- locked  out  1  sticky lockout flag.

Behaviour:
- Reset, asynchronous: state=IDLE, key register=0, all outputs 0, err_cnt=0, locked=0, timers=0.
- All outputs are registered.
- State machine:
  - IDLE -> ERR when fetch_req=1 and (fetch_priv=0 or debug_mode=1 or locked=1).
  - IDLE -> REQ when fetch_req=1 and none of those conditions hold; the wait timer is cleared.
  - REQ:
    - key_rd_req=1 for every cycle in REQ; it drops in the cycle after ack is seen.
    - On key_rd_ack=1, key_rd_data is captured into the key register -> DELIVER, hold timer cleared.
    - If the wait timer reaches TIMEOUT-1 without ack -> ERR.
    - If debug_mode=1 -> ERR; this takes priority over a same-cycle ack, which is discarded.
  - DELIVER:
    - key_valid=1 and key_out=key register.
    - Exits to ZERO on any of: key_consume=1, hold timer at HOLD_MAX-1, or debug_mode=1.
  - ZERO:
    - Key register cleared, key_valid=0, key_out=0.
    - fetch_done=1 for one cycle only when DELIVER was left via key_consume or hold timeout; not when left via debug_mode.
    - -> IDLE.
  - ERR:
    - fetch_err=1 for one cycle; err_cnt increments, saturating at 15.
    - If the new err_cnt >= MAX_ERR, locked is set; it clears only on reset.
    - -> IDLE.
- Latency:
  - fetch_req accepted at edge N gives key_rd_req=1 after edge N.
  - Ack sampled at edge M gives key_valid=1 after edge M.
  - Minimum request to key_valid is 2 cycles.
- fetch_req outside IDLE is ignored; there is no queuing.
- key_rd_ack outside REQ is ignored and never loads the key register.
- key_out is never nonzero unless key_valid=1; the key register is zero in every state except DELIVER.
- locked=1 never blocks a DELIVER already in progress; it only blocks the next fetch.

Decomposition:
- Shared package key_sec_pkg:
  - State enum: IDLE, REQ, DELIVER, ZERO, ERR.
  - KEY_W default and the err_cnt width constant (4).
- One natural sub-module: key_fault_monitor, holding err_cnt, saturation and the sticky locked flag.
  - Input: err pulse.
  - Output: locked.
  - The FSM stays in the top level.

Test Plan:
- Fetch with ack delay: fetch_req=1, fetch_priv=1, ack 3 cycles after key_rd_req, data 32'hA5A5_1234.
  - key_valid=1 with key_out=32'hA5A5_1234; key_consume next cycle -> fetch_done pulse, key_out=0.
- Unprivileged fetch: fetch_priv=0 -> fetch_err pulse, key_rd_req never asserts.
  - Three such requests with MAX_ERR=3 -> locked=1.
  - A subsequent privileged fetch also errors.
- Ack timeout: no ack with TIMEOUT=16 -> key_rd_req high exactly 16 cycles, then fetch_err.
  - A late ack carrying 32'hDEAD_BEEF is ignored and key_out stays 0.
- Hold timeout: delivery with no key_consume and HOLD_MAX=8 -> key_valid high exactly 8 cycles, then zero and fetch_done.
- Debug forces zeroize: debug_mode asserted in the 2nd DELIVER cycle -> next cycle key_valid=0, key_out=0, no fetch_done.
  - debug_mode coinciding with ack in REQ -> fetch_err, key never loaded.
- Reset mid-operation: rst_n low during DELIVER with key 32'hCAFE_F00D -> key_out=0 and key_valid=0 immediately (asynchronous).
  - locked and err_cnt cleared.

Source files
------------

// File: rtl/key_sec_pkg.sv
// Shared types and constants for the secure key store read path.
package key_sec_pkg;

  localparam int unsigned KEY_W_DEF = 32;
  localparam int unsigned ERR_CNT_W = 4;
  localparam int unsigned TIMER_W   = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_DELIVER = 3'd2,
    ST_ZERO    = 3'd3,
    ST_ERR     = 3'd4
  } key_state_e;

endpackage

// File: rtl/key_fault_monitor.sv
// Counts fetch faults (saturating) and raises a sticky lockout at MAX_ERR.
module key_fault_monitor
  import key_sec_pkg::*;
#(
  parameter int unsigned MAX_ERR = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic err_pulse,
  output logic locked
);

  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 locked_q, locked_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    locked_d  = locked_q;
    if (err_pulse) begin
      if (err_cnt_q != {ERR_CNT_W{1'b1}}) begin
        err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      end
      if (32'(err_cnt_d) >= MAX_ERR) begin
        locked_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
      locked_q  <= 1'b0;
    end else begin
      err_cnt_q <= err_cnt_d;
      locked_q  <= locked_d;
    end
  end

  assign locked = locked_q;

endmodule

// File: rtl/key_fetch_client.sv
// Requester side of the key store read path: privileged fetch, bounded
// delivery window, zeroize on exit, fault lockout.
module key_fetch_client
  import key_sec_pkg::*;
#(
  parameter int unsigned KEY_W    = KEY_W_DEF,
  parameter int unsigned TIMEOUT  = 16,
  parameter int unsigned HOLD_MAX = 8,
  parameter int unsigned MAX_ERR  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fetch_req,
  input  logic             fetch_priv,
  input  logic             debug_mode,
  input  logic             key_consume,
  output logic             key_rd_req,
  input  logic             key_rd_ack,
  input  logic [KEY_W-1:0] key_rd_data,
  output logic             key_valid,
  output logic [KEY_W-1:0] key_out,
  output logic             fetch_done,
  output logic             fetch_err,
  output logic             locked
);

  key_state_e         state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic               done_ok_q, done_ok_d;
  logic               key_rd_req_q, key_rd_req_d;
  logic               key_valid_q, key_valid_d;
  logic               fetch_done_q, fetch_done_d;
  logic               fetch_err_q, fetch_err_d;
  logic               err_c;

  // Next state, timers, key register and registered output values.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    done_ok_d = done_ok_q;
    key_d     = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (fetch_req) begin
          timer_d = '0;
          if (!fetch_priv || debug_mode || locked) state_d = ST_ERR;
          else                                     state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        timer_d = timer_q + TIMER_W'(1);
        // Debug wins over a coincident ack so the key is never loaded.
        if (debug_mode) begin
          state_d = ST_ERR;
        end else if (key_rd_ack) begin
          state_d = ST_DELIVER;
          timer_d = '0;
          key_d   = key_rd_data;
        end else if (timer_q == TIMER_W'(TIMEOUT - 1)) begin
          state_d = ST_ERR;
        end
      end
      ST_DELIVER: begin
        timer_d = timer_q + TIMER_W'(1);
        key_d   = key_q;
        if (debug_mode) begin
          state_d   = ST_ZERO;
          done_ok_d = 1'b0;
          key_d     = '0;
        end else if (key_consume || timer_q == TIMER_W'(HOLD_MAX - 1)) begin
          state_d   = ST_ZERO;
          done_ok_d = 1'b1;
          key_d     = '0;
        end
      end
      ST_ZERO: begin
        state_d   = ST_IDLE;
        done_ok_d = 1'b0;
      end
      ST_ERR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    err_c        = (state_q != ST_ERR) && (state_d == ST_ERR);
    key_rd_req_d = (state_d == ST_REQ);
    key_valid_d  = (state_d == ST_DELIVER);
    fetch_done_d = (state_d == ST_ZERO) && done_ok_d;
    fetch_err_d  = (state_d == ST_ERR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      key_q        <= '0;
      done_ok_q    <= 1'b0;
      key_rd_req_q <= 1'b0;
      key_valid_q  <= 1'b0;
      fetch_done_q <= 1'b0;
      fetch_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      key_q        <= key_d;
      done_ok_q    <= done_ok_d;
      key_rd_req_q <= key_rd_req_d;
      key_valid_q  <= key_valid_d;
      fetch_done_q <= fetch_done_d;
      fetch_err_q  <= fetch_err_d;
    end
  end

  key_fault_monitor #(
    .MAX_ERR (MAX_ERR)
  ) u_fault_monitor (
    .clk       (clk),
    .rst_n     (rst_n),
    .err_pulse (err_c),
    .locked    (locked)
  );

  assign key_rd_req = key_rd_req_q;
  assign key_valid  = key_valid_q;
  assign key_out    = key_q;
  assign fetch_done = fetch_done_q;
  assign fetch_err  = fetch_err_q;

endmodule
